// File: rtl/wddl_dualrail_rx_if.sv
// Bundle of the dual-rail receive interface.
//
// Signals:
//   prechrg_i   phase signal, 1 = precharge, 0 = evaluate
//   t_i, f_i    true / false rails of the WDDL pair
//   data_o      last completed WIDTH-bit word
//   valid_o     one-cycle pulse, data_o holds a new word
//   busy_o      partial word in progress
//   err_o       one-cycle pulse on a protocol violation
//   err_code_o  code of the most recent error (0 none, 1 precharge
//               violation, 2 both rails high, 3 missing/unstable evaluate)
//
// Modports:
//   master  the WDDL side: drives phase and rails, observes results
//   slave   the receiver: samples phase and rails, drives results
interface wddl_dualrail_rx_if #(
  parameter int WIDTH = 8
);
  logic             prechrg_i;
  logic             t_i;
  logic             f_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             busy_o;
  logic             err_o;
  logic [1:0]       err_code_o;

  modport master (
    output prechrg_i, t_i, f_i,
    input  data_o, valid_o, busy_o, err_o, err_code_o
  );

  modport slave (
    input  prechrg_i, t_i, f_i,
    output data_o, valid_o, busy_o, err_o, err_code_o
  );
endinterface

// File: rtl/wddl_dualrail_rx.sv
// WDDL dual-rail receive decoder.
//
// Samples a dual-rail pair plus the shared precharge/evaluate phase signal,
// checks each phase for protocol violations, decodes every evaluate phase
// into one single-rail bit and assembles WIDTH bits into a word.
//
// Parameters:
//   WIDTH      bits per word, 2..16
//   MSB_FIRST  1 = first received bit lands in data_o[WIDTH-1],
//              0 = first received bit lands in data_o[0]
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   rst_n  synchronous, active-low reset
//   rx     wddl_dualrail_rx_if slave modport (phase, rails in; word,
//          valid, busy, error pulse and error code out)
module wddl_dualrail_rx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wddl_dualrail_rx_if.slave     rx
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ERR_PRE  = 2'd1;
  localparam logic [1:0] ERR_BOTH = 2'd2;
  localparam logic [1:0] ERR_EVAL = 2'd3;

  typedef enum logic [1:0] {
    SYNC,
    PRE,
    EVAL_WAIT,
    EVAL_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             held_q;

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             err_vld_p1;
  logic [1:0]       err_code_p1;

  logic [1:0]       rails;
  logic             cap;
  logic             err;
  logic [1:0]       code;
  logic             word_done;
  logic [CNT_W-1:0] pos;

  assign rails = {rx.t_i, rx.f_i};

  // Protocol FSM: next state, capture strobe and error classification.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    err     = 1'b0;
    code    = 2'd0;
    unique case (state_q)
      SYNC: begin
        // Errors are suppressed until a clean precharge aligns us.
        if (rx.prechrg_i && rails == 2'b00) state_d = PRE;
      end
      PRE: begin
        if (rx.prechrg_i) begin
          if (rails != 2'b00) begin
            err  = 1'b1;
            code = ERR_PRE;
          end
        end else begin
          unique case (rails)
            2'b00: state_d = EVAL_WAIT;
            2'b11: begin
              err  = 1'b1;
              code = ERR_BOTH;
            end
            default: begin
              cap     = 1'b1;
              state_d = EVAL_HOLD;
            end
          endcase
        end
      end
      EVAL_WAIT: begin
        if (!rx.prechrg_i) begin
          unique case (rails)
            2'b00: state_d = EVAL_WAIT;
            2'b11: begin
              err  = 1'b1;
              code = ERR_BOTH;
            end
            default: begin
              cap     = 1'b1;
              state_d = EVAL_HOLD;
            end
          endcase
        end else begin
          // Evaluate ended empty; rails 11 here still reports as code 2.
          err  = 1'b1;
          code = (rails == 2'b11) ? ERR_BOTH : ERR_EVAL;
        end
      end
      EVAL_HOLD: begin
        if (!rx.prechrg_i) begin
          if (rails == 2'b11) begin
            err  = 1'b1;
            code = ERR_BOTH;
          end else if (rails != {held_q, ~held_q}) begin
            // Codeword dropped to spacer or flipped mid-evaluate.
            err  = 1'b1;
            code = ERR_EVAL;
          end
        end else if (rails != 2'b00) begin
          err  = 1'b1;
          code = ERR_PRE;
        end else begin
          state_d = PRE;
        end
      end
      default: state_d = SYNC;
    endcase
    if (err) state_d = SYNC;
  end

  // Bit placement: counter indexes from the MSB or LSB end.
  assign pos = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;

  // Word assembly: an error discards the partial word.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (err) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (cap) begin
      shreg_d[pos] = rx.t_i;
      if (cnt_q == CNT_LAST) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      err_vld_p1  <= 1'b0;
      err_code_p1 <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_p1     <= word_done;
      err_vld_p1 <= err;
      if (word_done) begin
        data_p1 <= shreg_d;
        shreg_q <= '0;
      end else begin
        shreg_q <= shreg_d;
      end
      if (err) err_code_p1 <= code;
    end
  end

  // Captured codeword for the hold-stability check; only read after a capture.
  always_ff @(posedge clk) begin
    if (cap) held_q <= rx.t_i;
  end

  assign rx.data_o     = data_p1;
  assign rx.valid_o    = vld_p1;
  assign rx.err_o      = err_vld_p1;
  assign rx.err_code_o = err_code_p1;
  assign rx.busy_o     = (cnt_q != '0);

endmodule

// File: tb/tb_wddl_dualrail_rx.sv
// Scoreboard bench for wddl_dualrail_rx. Two instances (MSB-first and
// LSB-first) share one stimulus stream; expected word/error events and
// steady-state snapshots are queued by the stimulus process and checked by
// an independent monitor on the falling clock edge.
module tb_wddl_dualrail_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic prechrg;
  logic t_r;
  logic f_r;

  wddl_dualrail_rx_if #(.WIDTH(8)) ifa ();
  wddl_dualrail_rx_if #(.WIDTH(8)) ifb ();

  assign ifa.prechrg_i = prechrg;
  assign ifa.t_i       = t_r;
  assign ifa.f_i       = f_r;
  assign ifb.prechrg_i = prechrg;
  assign ifb.t_i       = t_r;
  assign ifb.f_i       = f_r;

  wddl_dualrail_rx #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (ifa)
  );

  wddl_dualrail_rx #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (ifb)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] da;
    logic [7:0] db;
    logic [1:0] code;
    int         gap;
  } ev_t;

  typedef struct {
    string      name;
    logic       busy;
    logic [1:0] code;
    logic [7:0] da;
    logic [7:0] db;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];

  int n_cmp   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_vld = 0;
  bit mon_en  = 1'b0;
  bit done    = 1'b0;
  bit drained = 1'b0;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents an output event.
  initial begin
    ev_t e;
    st_t s;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (ifa.valid_o === 1'b1 || ifa.err_o === 1'b1 ||
            ifb.valid_o === 1'b1 || ifb.err_o === 1'b1) begin
          if (ev_q.size() == 0) begin
            check("unexpected_output",
                  {28'd0, ifa.valid_o, ifa.err_o, ifb.valid_o, ifb.err_o}, 32'd0);
          end else begin
            e = ev_q.pop_front();
            if (e.is_err) begin
              check("err_a", ifa.err_o, 1);
              check("valid_a_during_err", ifa.valid_o, 0);
              check("err_code_a", ifa.err_code_o, e.code);
              check("err_b", ifb.err_o, 1);
              check("valid_b_during_err", ifb.valid_o, 0);
              check("err_code_b", ifb.err_code_o, e.code);
            end else begin
              check("valid_a", ifa.valid_o, 1);
              check("err_a_during_valid", ifa.err_o, 0);
              check("data_a", ifa.data_o, e.da);
              check("valid_b", ifb.valid_o, 1);
              check("err_b_during_valid", ifb.err_o, 0);
              check("data_b", ifb.data_o, e.db);
              if (e.gap != 0) check("valid_spacing", cyc - last_vld, e.gap);
              last_vld = cyc;
            end
          end
        end
        while (st_q.size() > 0) begin
          s = st_q.pop_front();
          check({s.name, "_busy_a"}, ifa.busy_o, s.busy);
          check({s.name, "_code_a"}, ifa.err_code_o, s.code);
          check({s.name, "_data_a"}, ifa.data_o, s.da);
          check({s.name, "_busy_b"}, ifb.busy_o, s.busy);
          check({s.name, "_code_b"}, ifb.err_code_o, s.code);
          check({s.name, "_data_b"}, ifb.data_o, s.db);
        end
        if (done && !drained) begin
          drained = 1'b1;
          check("pending_expectations", ev_q.size(), 0);
        end
      end
    end
  end

  task automatic drive(input logic p, input logic t, input logic f);
    prechrg = p;
    t_r     = t;
    f_r     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, b, ~b);
  endtask

  task automatic expect_word(input logic [7:0] w, input int gap);
    ev_t e;
    e.is_err = 1'b0;
    e.da     = w;
    e.db     = rev8(w);
    e.code   = 2'd0;
    e.gap    = gap;
    ev_q.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] code);
    ev_t e;
    e.is_err = 1'b1;
    e.da     = 8'h00;
    e.db     = 8'h00;
    e.code   = code;
    e.gap    = 0;
    ev_q.push_back(e);
  endtask

  task automatic expect_state(input string name, input logic busy,
                              input logic [1:0] code, input logic [7:0] da);
    st_t s;
    s.name = name;
    s.busy = busy;
    s.code = code;
    s.da   = da;
    s.db   = rev8(da);
    st_q.push_back(s);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    expect_word(w, gap);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    rst_n   = 1'b0;
    prechrg = 1'b1;
    t_r     = 1'b0;
    f_r     = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
    expect_state("reset", 1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;

    // Nominal word
    drive(1'b1, 1'b0, 1'b0);
    send_word(8'hA5, 0);
    expect_state("nominal_a5", 1'b0, 2'd0, 8'hA5);

    // Both rails high in evaluate of bit 3
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    expect_state("mid_word", 1'b1, 2'd0, 8'hA5);
    drive(1'b1, 1'b0, 1'b0);
    expect_err(2'd2);
    drive(1'b0, 1'b1, 1'b1);
    expect_state("after_both_high", 1'b0, 2'd2, 8'hA5);
    drive(1'b1, 1'b0, 1'b0);
    send_word(8'h3C, 0);
    expect_state("recover_3c", 1'b0, 2'd2, 8'h3C);

    // Precharge violation after bit 5
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    expect_err(2'd1);
    drive(1'b1, 1'b1, 1'b0);
    expect_state("after_pre_viol", 1'b0, 2'd1, 8'h3C);
    drive(1'b1, 1'b0, 1'b0);
    send_word(8'h0F, 0);
    expect_state("recover_0f", 1'b0, 2'd1, 8'h0F);

    // Unstable evaluate: 10 for two cycles, then 01
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_err(2'd3);
    drive(1'b0, 1'b0, 1'b1);
    expect_state("unstable_eval", 1'b0, 2'd3, 8'h0F);

    // Missing evaluate: two spacer evaluate cycles, then precharge
    drive(1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expect_err(2'd3);
    drive(1'b1, 1'b0, 1'b0);
    expect_state("missing_eval", 1'b0, 2'd3, 8'h0F);

    // Reset after 5 bits
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    expect_state("reset_mid_word", 1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;

    // 0x81 with 3-cycle phases, data in the 2nd evaluate cycle
    begin
      logic [7:0] w;
      w = 8'h81;
      expect_word(w, 0);
      for (int i = 7; i >= 0; i--) begin
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, w[i], ~w[i]);
        drive(1'b0, w[i], ~w[i]);
      end
    end
    expect_state("multi_cycle_81", 1'b0, 2'd0, 8'h81);

    // Bit order: 1,0,...,0 then eight ones back-to-back
    send_word(8'h80, 0);
    send_word(8'hFF, 16);
    expect_state("back_to_back_ff", 1'b0, 2'd0, 8'hFF);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wddl_dualrail_rx.md
# wddl_dualrail_rx

Receive-side decoder for the WDDL (wave dynamic differential logic) datapath. It samples a dual-rail pair (true/false rails) produced by a `wddl_dflipflop` chain, together with the shared precharge/evaluate phase signal. It checks every phase for protocol violations, decodes each evaluate phase into one single-rail bit, and assembles bits into `WIDTH`-bit words. It sits at the boundary where the secure WDDL domain hands results back to ordinary single-rail logic.

## Interface
Parameters:
- `WIDTH`, default 8: bits per assembled word, 2..16.
- `MSB_FIRST`, default 1: 1 = first received bit lands in `data_o[WIDTH-1]`; 0 = first bit lands in `data_o[0]`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `prechrg_i`  in  1  phase signal: 1 = precharge, 0 = evaluate. Synchronous to `clk`; no synchronizer inside.
- `t_i`  in  1  true rail.
- `f_i`  in  1  false rail.
- `data_o`  out  WIDTH  last completed word.
- `valid_o`  out  1  one-cycle pulse; `data_o` holds a new word.
- `busy_o`  out  1  partial word in progress (bit counter nonzero).
- `err_o`  out  1  one-cycle pulse on a protocol violation.
- `err_code_o`  out  2  code of the most recent error: 0 none, 1 precharge violation, 2 both rails high, 3 missing or unstable evaluate.

## Operation
Rail codewords, written as {t,f}:
- 00 = spacer.
- 10 = logic 1.
- 01 = logic 0.
- 11 = illegal.

FSM states are SYNC, PRE, EVAL_WAIT and EVAL_HOLD. Evaluation happens once per posedge.
- **SYNC** (reset state):
  - If `prechrg_i`=1 and rails are 00, go to PRE.
  - Otherwise stay. No errors are reported while in SYNC.
- **PRE**:
  - `prechrg_i`=1, rails 00: stay.
  - `prechrg_i`=1, rails ≠00: error 1.
  - `prechrg_i`=0, rails 00: go to EVAL_WAIT.
  - `prechrg_i`=0, rails 10/01: capture the bit, go to EVAL_HOLD.
  - `prechrg_i`=0, rails 11: error 2.
- **EVAL_WAIT**:
  - `prechrg_i`=0, rails 00: stay.
  - `prechrg_i`=0, rails 10/01: capture the bit, go to EVAL_HOLD.
  - `prechrg_i`=0, rails 11: error 2.
  - `prechrg_i`=1: error 3 (evaluate phase ended with no data).
- **EVAL_HOLD**:
  - `prechrg_i`=0, same codeword as captured: stay.
  - `prechrg_i`=0, rails 11: error 2.
  - `prechrg_i`=0, any other change (00 or flipped value): error 3.
  - `prechrg_i`=1, rails 00: go to PRE.
  - `prechrg_i`=1, rails ≠00: error 1.

Capture and word assembly:
- The captured bit value is `t_i`.
- The bit is written into the shift register at the position given by `MSB_FIRST` and the bit counter.
- The counter counts 0..WIDTH-1. Capturing with counter = WIDTH-1 completes a word, and the counter wraps to 0.

Any error:
- Pulse `err_o` and load `err_code_o`; `err_code_o` then holds until the next error or reset.
- Discard the partial word: counter to 0, shift register to 0.
- Go to SYNC.
- `data_o` is unchanged.
- Precedence when several conditions apply in one cycle: code 2 over code 3.

Phases may last one or more clk cycles. The nominal rate is one cycle per phase.

## Timing
Reset values, applied at the first posedge with `rst_n`=0:
- State SYNC; counter 0; shift register 0.
- `data_o`=0, `valid_o`=0, `busy_o`=0, `err_o`=0, `err_code_o`=0.

Reset mid-word discards the partial word. At least one clean precharge cycle (rails 00) is required before the next capture.

Latencies, measured from the sampling posedge:
- Word completion: `data_o` updates and `valid_o`=1 are registered outputs, visible right after the edge that samples the last bit. `valid_o` is high for exactly one cycle.
- `err_o`: visible right after the violating sampling edge, high for one cycle.
- `busy_o`: reflects the registered counter being nonzero.

Minimum word time is 2·WIDTH cycles: one precharge cycle plus one evaluate cycle per bit.

`valid_o` and `err_o` are never high in the same cycle.

## Test plan
1. **Nominal word:** reset, then a clean sync precharge, then 1-cycle alternating phases carrying 0xA5 MSB-first. Expect `valid_o` high for 1 cycle with `data_o`=0xA5, `err_o` never high, `busy_o` back to 0.
2. **Both rails high:** rails 11 in the evaluate phase of bit 3. Expect an `err_o` pulse, `err_code_o`=2, no `valid_o`, `busy_o`=0. After a clean precharge, send 0x3C; expect `data_o`=0x3C and `err_code_o` still 2.
3. **Precharge violation:** precharge cycle with `t_i`=1 after bit 5. Expect `err_code_o`=1, word dropped. A recovered word 0x0F must decode correctly.
4. **Missing and unstable evaluate:**
   - A 2-cycle evaluate with rails 00 throughout, then `prechrg_i` rises: expect `err_code_o`=3.
   - Separately, a 3-cycle evaluate with rails 10 then 01: expect `err_code_o`=3.
5. **Reset mid-word and multi-cycle phases:**
   - Drop `rst_n` after 5 bits: all outputs 0 the next cycle.
   - Release, then send 0x81 with 3-cycle phases and data arriving in the 2nd evaluate cycle: expect `data_o`=0x81, no error.
6. **LSB-first:** `MSB_FIRST`=0, `WIDTH`=8, bits 1,0,0,0,0,0,0,0. Expect `data_o`=0x01. Then 8 ones back-to-back: expect `data_o`=0xFF, with `valid_o` pulses 16 cycles apart.
